// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scan-out with ping-pong row prefetch; VGA_PALETTE_EN adds fg/bg/border colour inputs
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SRC_W      = 640,
    parameter int SRC_H      = 64,
    parameter int VSCALE     = 1,
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 14,
    parameter int ROW_STRIDE = 256
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              lcdon,
    output logic              vram_req,
    output logic [ADDR_W-1:0] vram_a,
    input  logic              vram_ack,
    input  logic [DATA_W-1:0] vram_di,
`ifdef VGA_PALETTE_EN
    input  logic [11:0]       fg_rgb,
    input  logic [11:0]       bg_rgb,
    input  logic [11:0]       border_rgb,
`endif
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [11:0]       rgb,
    output logic              underrun,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WORDS   = SRC_W / DATA_W;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int WA      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BA      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} fstate_t;

    logic [11:0] fg, bg, border;
`ifdef VGA_PALETTE_EN
    assign fg     = fg_rgb;
    assign bg     = bg_rgb;
    assign border = border_rgb;
`else
    assign fg     = 12'h000;
    assign bg     = 12'hFFF;
    assign border = 12'hFFF;
`endif

    logic [HW-1:0]     hcount;
    logic [VW-1:0]     vcount;
    fstate_t           state, state_n;
    logic [WA-1:0]     word, word_n;
    logic              req_n, pending, pend_n, abort, abort_n, wr_en;
    logic [ADDR_W-1:0] addr_n, pbase, pbase_n, sbase;
    logic              disp, line_ok, line_start, want, start;
    logic [DATA_W-1:0] lbuf [2][WORDS];
    int                hi, vi, ni, nrow;

    always_ff @(posedge clk25) begin
        if (reset || !lcdon) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == HW'(H_TOTAL - 1)) begin
            hcount <= '0;
            vcount <= (vcount == VW'(V_TOTAL - 1)) ? '0 : vcount + VW'(1);
        end else begin
            hcount <= hcount + HW'(1);
        end
    end

    // The row needed by the *next* line is decided at hcount==0 of this line.
    always_comb begin
        hi         = int'(hcount);
        vi         = int'(vcount);
        ni         = (vi == V_TOTAL - 1) ? 0 : vi + 1;
        nrow       = ni / VSCALE;
        want       = (ni < V_ACTIVE) && (nrow < SRC_H);
        line_start = lcdon && (hcount == '0);
        start      = line_start ? want : pending;
        sbase      = line_start ? ADDR_W'(nrow * ROW_STRIDE) : pbase;
    end

    always_comb begin
        state_n = state;
        word_n  = word;
        req_n   = vram_req;
        addr_n  = vram_a;
        pend_n  = pending;
        pbase_n = pbase;
        abort_n = abort;
        wr_en   = 1'b0;
        if (!lcdon) begin
            pend_n  = 1'b0;
            abort_n = 1'b0;
            if (!vram_req || vram_ack) begin
                req_n   = 1'b0;
                addr_n  = '0;
                state_n = IDLE;
            end
        end else begin
            if (line_start) begin
                pend_n  = want;
                pbase_n = sbase;
            end
            case (state)
                FETCH: begin
                    if (line_start)
                        abort_n = 1'b1;
                    if (vram_ack) begin
                        if (abort || line_start) begin
                            // Late row: let the outstanding word land, then restart.
                            req_n   = 1'b0;
                            abort_n = 1'b0;
                            state_n = IDLE;
                        end else begin
                            wr_en = 1'b1;
                            if (word == WA'(WORDS - 1)) begin
                                req_n   = 1'b0;
                                state_n = DONE;
                            end else begin
                                word_n = word + WA'(1);
                                addr_n = vram_a + ADDR_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_n = FETCH;
                        req_n   = 1'b1;
                        addr_n  = sbase;
                        word_n  = '0;
                        pend_n  = 1'b0;
                    end else if (line_start) begin
                        state_n = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state    <= IDLE;
            word     <= '0;
            vram_req <= 1'b0;
            vram_a   <= '0;
            pending  <= 1'b0;
            pbase    <= '0;
            abort    <= 1'b0;
            disp     <= 1'b0;
            line_ok  <= 1'b0;
        end else begin
            state    <= state_n;
            word     <= word_n;
            vram_req <= req_n;
            vram_a   <= addr_n;
            pending  <= pend_n;
            pbase    <= pbase_n;
            abort    <= abort_n;
            if (line_start) begin
                disp    <= ~disp;
                line_ok <= (state == DONE);
            end
            if (!lcdon)
                line_ok <= 1'b0;
        end
    end

    always_ff @(posedge clk25) begin
        if (wr_en)
            lbuf[~disp][word] <= vram_di;
    end

    // Stage 1: decode counters; at hcount==0 the bank swap is not yet visible in disp.
    logic          rd_bank, ok_eff, vis, insrc, pix;
    logic [WA-1:0] widx;
    logic [BA-1:0] bidx;
    logic [11:0]   colour;
    logic          hs_c, vs_c;

    always_comb begin
        rd_bank = line_start ? ~disp : disp;
        ok_eff  = line_start ? (state == DONE) : line_ok;
        vis     = (hi < H_ACTIVE) && (vi < V_ACTIVE);
        insrc   = (hi < SRC_W) && ((vi / VSCALE) < SRC_H);
        widx    = insrc ? WA'(hi / DATA_W) : '0;
        bidx    = BA'(hi % DATA_W);
        pix     = lbuf[rd_bank][widx][bidx];
        hs_c    = !((hi >= H_ACTIVE + H_FP) && (hi < H_ACTIVE + H_FP + H_SYNC));
        vs_c    = !((vi >= V_ACTIVE + V_FP) && (vi < V_ACTIVE + V_FP + V_SYNC));
        if (!vis)
            colour = 12'h000;
        else if (insrc && ok_eff)
            colour = pix ? fg : bg;
        else
            colour = border;
    end

    logic        s1_hs, s1_vs, s1_de, s1_fs, s1_ur;
    logic [11:0] s1_rgb;

    always_ff @(posedge clk25) begin
        if (reset || !lcdon) begin
            s1_hs <= 1'b1; s1_vs <= 1'b1; s1_de <= 1'b0; s1_fs <= 1'b0; s1_ur <= 1'b0; s1_rgb <= '0;
            hsync <= 1'b1; vsync <= 1'b1; de <= 1'b0; frame_start <= 1'b0; underrun <= 1'b0; rgb <= '0;
        end else begin
            s1_hs  <= hs_c;
            s1_vs  <= vs_c;
            s1_de  <= vis;
            s1_fs  <= (hcount == '0) && (vcount == '0);
            s1_ur  <= line_start && (state == FETCH);
            s1_rgb <= colour;
            hsync       <= s1_hs;
            vsync       <= s1_vs;
            de          <= s1_de;
            frame_start <= s1_fs;
            underrun    <= s1_ur;
            rgb         <= s1_rgb;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout on a reduced timing geometry
module tb_vga_scanout;
    localparam int HT = 24, VT = 17, FR = HT * VT;

    logic        clk25 = 1'b0, reset = 1'b1, lcdon = 1'b0, vram_ack = 1'b0;
    logic [3:0]  vram_di = '0;
    logic        vram_req, hsync, vsync, de, underrun, frame_start;
    logic [13:0] vram_a;
    logic [11:0] rgb;

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SRC_W(8), .SRC_H(4), .VSCALE(2), .DATA_W(4), .ADDR_W(14), .ROW_STRIDE(256)
    ) dut (
        .clk25(clk25), .reset(reset), .lcdon(lcdon),
        .vram_req(vram_req), .vram_a(vram_a), .vram_ack(vram_ack), .vram_di(vram_di),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
        .underrun(underrun), .frame_start(frame_start)
    );

    always #20 clk25 = ~clk25;

    int checks = 0, failures = 0;
    int gk = 0, mk = 0, ur_f = -1, ur_v = 4;
    int lat_max = 0, waitc = 0, hold = 0, cur_a = 0;
    bit sb_on = 0, addr_chk = 0, arm = 0, busy = 0, force_hold = 0;
    logic [16:0] exp_q[$];
    int          addr_q[$];

    function automatic logic [3:0] pat(int a);
        return 4'(((a / 256) * 5 + (a % 256) * 3 + 6) & 15);
    endfunction

    function automatic logic [16:0] model(int k);
        int h, v, f;
        logic hs, vs, de_e, fs, ur, ok;
        logic [3:0] wd;
        logic [11:0] c;
        h = k % HT; v = (k / HT) % VT; f = k / FR;
        de_e = (h < 16) && (v < 12);
        hs = !((h >= 18) && (h < 21));
        vs = !((v >= 13) && (v < 15));
        fs = (h == 0) && (v == 0);
        ok = !(f == 0 && v == 0) && !(f == ur_f && v == ur_v);
        ur = (h == 0) && (f == ur_f) && (v == ur_v);
        if (!de_e) c = 12'h000;
        else if (ok && h < 8 && v / 2 < 4) begin
            wd = pat((v / 2) * 256 + h / 4);
            c = wd[h % 4] ? 12'h000 : 12'hFFF;
        end else c = 12'hFFF;
        return {hs, vs, de_e, fs, ur, c};
    endfunction

    always @(posedge clk25) begin
        if (sb_on) begin
            exp_q.push_back(model(gk));
            if (addr_chk && (gk % HT) == 0) begin
                int n;
                n = ((gk / HT) % VT + 1) % VT;
                if (n < 12 && n / 2 < 4) begin
                    addr_q.push_back((n / 2) * 256);
                    addr_q.push_back((n / 2) * 256 + 1);
                end
            end
            gk++;
        end
    end

    always @(negedge clk25) begin
        if (sb_on && exp_q.size() > 1) begin
            logic [16:0] e, act;
            e = exp_q.pop_front();
            act = {hsync, vsync, de, frame_start, underrun, rgb};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL scan k=%0d actual=%h required=%h", mk, act, e);
            end
            mk++;
        end
    end

    always @(negedge clk25) begin
        vram_ack = 1'b0;
        if (vram_req && !force_hold) begin
            if (!busy) begin
                busy = 1; cur_a = int'(vram_a);
                if (arm && vram_a == 14'd512) begin hold = 30; arm = 0; end
            end else begin
                checks++;
                if (int'(vram_a) != cur_a) begin
                    failures++;
                    $display("FAIL addr_stable actual=%0d required=%0d", vram_a, cur_a);
                end
            end
            if (hold > 0) hold--;
            else if (waitc > 0) waitc--;
            else begin
                vram_ack = 1'b1;
                vram_di  = pat(int'(vram_a));
                busy = 0;
                waitc = (lat_max > 0) ? int'($urandom_range(0, lat_max)) : 0;
                if (addr_chk) begin
                    checks++;
                    if (addr_q.size() == 0) begin
                        failures++;
                        $display("FAIL vram_a unexpected fetch actual=%0d", vram_a);
                    end else begin
                        int ea;
                        ea = addr_q.pop_front();
                        if (int'(vram_a) != ea) begin
                            failures++;
                            $display("FAIL vram_a actual=%0d required=%0d", vram_a, ea);
                        end
                    end
                end
            end
        end else if (!vram_req) busy = 0;
    end

    task automatic step();
        @(negedge clk25); #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_de"}, int'(de), 0);
        chk({tag, "_rgb"}, int'(rgb), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
    endtask

    task automatic run_test(int lat, bit arm_ur, bit achk);
        reset = 1; lcdon = 1;
        repeat (3) step();
        lat_max = lat; arm = arm_ur; ur_f = arm_ur ? 0 : -1; addr_chk = achk;
        exp_q.delete(); addr_q.delete();
        gk = 0; mk = 0; busy = 0; waitc = 0; hold = 0;
        reset = 0; sb_on = 1;
        repeat (2 * FR) step();
        sb_on = 0; addr_chk = 0;
    endtask

    task automatic wait_req(string nm);
        int n;
        n = 0;
        while (!vram_req && n < 60) begin step(); n++; end
        chk({nm, "_req_timeout"}, int'(vram_req), 1);
    endtask

    initial begin
        reset = 1; lcdon = 1;
        step(); step();
        chk_idle_outputs("reset");
        chk("reset_vram_req", int'(vram_req), 0);
        chk("reset_vram_a", int'(vram_a), 0);

        run_test(0, 0, 1);
        run_test(3, 0, 1);
        run_test(0, 1, 0);

        force_hold = 1; reset = 1; step();
        reset = 0;
        wait_req("midfetch_reset");
        step();
        reset = 1; step();
        chk_idle_outputs("midreset");
        chk("midreset_vram_req", int'(vram_req), 0);
        chk("midreset_vram_a", int'(vram_a), 0);

        reset = 0; busy = 0;
        wait_req("midfetch_lcdon");
        repeat (3) step();
        chk("pre_lcdoff_de", int'(de), 1);
        lcdon = 0; step();
        chk_idle_outputs("lcdoff");
        chk("lcdoff_req_held", int'(vram_req), 1);
        force_hold = 0; step(); step();
        chk("lcdoff_req_dropped", int'(vram_req), 0);
        chk("lcdoff_vram_a", int'(vram_a), 0);
        repeat (5) step();
        chk("lcdoff_stays_idle", int'(vram_req), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
